cfu_cmd_sequencer: RTL and testbench
====================================

Name: cfu_cmd_sequencer

Overview:
Hardware initiator for the CFU cmd/rsp protocol; it drives the CFU's port directly in place of the CPU. On start it fetches input and filter words from a 1-cycle-latency read port and issues the full command stream: reset, per-pair buffer store, SIMD8 MAC sweep, accumulator readback. The accumulator value is returned on result with a done pulse. Used to offload inner-product loops from firmware.

Parameters:
ADDR_W, 16, word-address width of memory read port
MAX_PAIRS, 82, maximum word pairs per job (164-word CFU buffer)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  1-cycle job request, sampled in IDLE only
num_pairs  in  8  word pairs to process, sampled with start
in_base  in  ADDR_W  word address of input words, sampled with start
flt_base  in  ADDR_W  word address of filter words, sampled with start
sel_buf  in  1  0: CFU buffer 0 (store f7=1, read f7=3); 1: buffer 1 (store f7=4, read f7=6)
busy  out  1  high from accepted start until done
done  out  1  1-cycle pulse at job end
err  out  1  valid with done; num_pairs > MAX_PAIRS
result  out  32  accumulator readback, valid from done until next start
mem_rd_en  out  1  read strobe
mem_addr  out  ADDR_W  read address
mem_rdata  in  32  read data, valid 1 cycle after mem_rd_en
cmd_valid  out  1  command valid
cmd_ready  in  1  CFU accepts command
cmd_function_id  out  10  {funct7[6:0], funct3[2:0]}
cmd_inputs_0  out  32  operand 0
cmd_inputs_1  out  32  operand 1
rsp_valid  in  1  CFU response valid
rsp_ready  out  1  sequencer accepts response
rsp_outputs_0  in  32  CFU response data

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-job aborts at once: cmd_valid/rsp_ready drop next cycle, no done.
- Job command stream, P = num_pairs, i = 0..P-1, total 3P+3 commands:
  1. RST: f3=0 f7=0, ops 0/0.
  2. Load, per i: SET f3=1 f7=0 in0=2i; then STORE f3=1 f7=(sel_buf?4:1), in0=mem[in_base+2i], in1=mem[in_base+2i+1].
  3. SET f3=1 f7=0 in0=0.
  4. MAC, per i: f3=0 f7=2, in0=mem[flt_base+2i], in1=mem[flt_base+2i+1]; the CFU auto-increments its count by 2.
  5. READ f3=1 f7=(sel_buf?6:3), ops 0/0; rsp_outputs_0 latched into result.
- States: IDLE, FETCH_LO, FETCH_HI, ISSUE, WAIT_RSP, DONE. Commands with memory operands pass FETCH_LO (rd_en, addr lo) -> FETCH_HI (rd_en, addr hi, capture lo) -> ISSUE (capture hi). Commands without memory operands go straight to ISSUE.
- Handshake: in ISSUE cmd_valid=1 with payload stable until the cycle cmd_valid&&cmd_ready. Next cycle cmd_valid=0, state WAIT_RSP, rsp_ready=1. The response is consumed on rsp_valid&&rsp_ready.
- Exactly one command outstanding. The next fetch/issue starts the cycle after response accept. Responses other than READ are discarded.
- Addresses are base+offset modulo 2^ADDR_W, wrapping silently. Offsets are 9-bit internal counters.
- P=0: RST, SET(0), READ only (3 commands).
- P>MAX_PAIRS: no commands and no memory reads. IDLE->DONE in 1 cycle, done=1, err=1, result unchanged.
- start while busy: ignored. done asserts one cycle after the READ response accept; busy falls in the same cycle.
- Operands in0/in1 are forwarded unmodified; the sequencer does no arithmetic on data.

Test Plan:
- P=1, sel_buf=0, in words 0x00000000/0x00000000, flt 0x01010101/0x01010101 -> 6 commands in order (0,0),(1,0 in0=0),(1,1),(1,0 in0=0),(0,2),(1,3); result=1024 (8x128x1), done 1 cycle, err=0.
- P=2, sel_buf=1, in_base=0xFFFE -> reads at 0xFFFE,0xFFFF,0x0000,0x0001 (wrap); store f7=4, read f7=6; 9 commands.
- Backpressure: cmd_ready low 3 cycles on the 2nd command -> cmd_valid held, function_id/inputs stable; rsp_valid delayed 5 cycles -> no new cmd until accepted.
- P=0 -> exactly 3 commands, zero mem reads, result=rsp of READ.
- P=83 -> done+err next cycle, cmd_valid never high, mem_rd_en never high; P=82 -> 249 commands, err=0.
- Reset asserted while in WAIT_RSP of a MAC -> next cycle busy=0, cmd_valid=0, rsp_ready=0, no done; new start runs a full job normally.

Source files
------------

// File: rtl/cfu_cmd_sequencer_if.sv
// CFU command/response channel plus the 1-cycle-latency word read port used
// to fetch operands. The sequencer is the master; CFU and memory sit on slave.
interface cfu_cmd_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [9:0]        cmd_function_id;
    logic [31:0]       cmd_inputs_0;
    logic [31:0]       cmd_inputs_1;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_outputs_0;

    modport master (
        output mem_rd_en, mem_addr, cmd_valid, cmd_function_id,
               cmd_inputs_0, cmd_inputs_1, rsp_ready,
        input  mem_rdata, cmd_ready, rsp_valid, rsp_outputs_0
    );

    modport slave (
        input  mem_rd_en, mem_addr, cmd_valid, cmd_function_id,
               cmd_inputs_0, cmd_inputs_1, rsp_ready,
        output mem_rdata, cmd_ready, rsp_valid, rsp_outputs_0
    );
endinterface

// File: rtl/cfu_cmd_sequencer.sv
// Hardware initiator for the CFU: runs one inner-product job per start.
// Stream: RST, {SET 2i, STORE in-pair} x P, SET 0, {MAC flt-pair} x P, READ.
// One command in flight at a time; only the READ response is kept.
module cfu_cmd_sequencer #(
    parameter int ADDR_W    = 16,
    parameter int MAX_PAIRS = 82
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        num_pairs,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] flt_base,
    input  logic              sel_buf,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       result,
    cfu_cmd_sequencer_if.master bus
);
    localparam logic [7:0] MAX_P = 8'(MAX_PAIRS);

    typedef enum logic [2:0] {IDLE, FETCH_LO, FETCH_HI, ISSUE, WAIT_RSP, DONE} state_t;
    typedef enum logic [2:0] {PH_RST, PH_SET, PH_STORE, PH_SET0, PH_MAC, PH_READ} phase_t;

    state_t            state, state_nxt;
    phase_t            phase, phase_nxt;
    logic [7:0]        idx, idx_nxt;
    logic [7:0]        npairs;
    logic [ADDR_W-1:0] in_r, flt_r;
    logic              sel_r;
    logic              err_r;
    logic [31:0]       lo_r, hi_r;
    logic              hi_fresh;

    logic [8:0]        offset;
    logic [ADDR_W-1:0] addr_lo;
    logic [31:0]       hi_now;
    logic [9:0]        fid;
    logic [31:0]       op0, op1;
    logic              last_pair;

    // Word offset 2i; addresses wrap modulo 2^ADDR_W.
    assign offset    = {idx, 1'b0};
    assign addr_lo   = ((phase == PH_MAC) ? flt_r : in_r) + ADDR_W'(offset);
    assign last_pair = (idx + 8'd1) == npairs;
    // The high word lands on mem_rdata during the first ISSUE cycle; forward it
    // then and hold the captured copy afterwards so the payload stays stable.
    assign hi_now    = hi_fresh ? bus.mem_rdata : hi_r;

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);
    assign err  = (state == DONE) && err_r;

    // Command payload decode from the current phase.
    always_comb begin
        fid = '0;
        op0 = '0;
        op1 = '0;
        case (phase)
            PH_SET:   begin fid = {7'd0, 3'd1}; op0 = {23'd0, offset}; end
            PH_STORE: begin fid = {(sel_r ? 7'd4 : 7'd1), 3'd1}; op0 = lo_r; op1 = hi_now; end
            PH_SET0:  fid = {7'd0, 3'd1};
            PH_MAC:   begin fid = {7'd2, 3'd0}; op0 = lo_r; op1 = hi_now; end
            PH_READ:  fid = {(sel_r ? 7'd6 : 7'd3), 3'd1};
            default:  fid = '0;
        endcase
    end

    // State register, job parameters, operand capture and result latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            phase    <= PH_RST;
            idx      <= '0;
            npairs   <= '0;
            in_r     <= '0;
            flt_r    <= '0;
            sel_r    <= 1'b0;
            err_r    <= 1'b0;
            lo_r     <= '0;
            hi_r     <= '0;
            hi_fresh <= 1'b0;
            result   <= '0;
        end else begin
            state    <= state_nxt;
            phase    <= phase_nxt;
            idx      <= idx_nxt;
            hi_fresh <= (state == FETCH_HI);
            if (state == IDLE && start) begin
                npairs <= num_pairs;
                in_r   <= in_base;
                flt_r  <= flt_base;
                sel_r  <= sel_buf;
                err_r  <= num_pairs > MAX_P;
            end
            if (state == FETCH_HI)
                lo_r <= bus.mem_rdata;
            if (hi_fresh)
                hi_r <= bus.mem_rdata;
            if (state == WAIT_RSP && bus.rsp_valid && phase == PH_READ)
                result <= bus.rsp_outputs_0;
        end
    end

    // Next-state, phase sequencing and bus outputs.
    always_comb begin
        state_nxt           = state;
        phase_nxt           = phase;
        idx_nxt             = idx;
        bus.mem_rd_en       = 1'b0;
        bus.mem_addr        = '0;
        bus.cmd_valid       = 1'b0;
        bus.cmd_function_id = '0;
        bus.cmd_inputs_0    = '0;
        bus.cmd_inputs_1    = '0;
        bus.rsp_ready       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_pairs > MAX_P) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = ISSUE;
                        phase_nxt = PH_RST;
                        idx_nxt   = '0;
                    end
                end
            end
            FETCH_LO: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_addr  = addr_lo;
                state_nxt     = FETCH_HI;
            end
            FETCH_HI: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_addr  = addr_lo + ADDR_W'(1);
                state_nxt     = ISSUE;
            end
            ISSUE: begin
                bus.cmd_valid       = 1'b1;
                bus.cmd_function_id = fid;
                bus.cmd_inputs_0    = op0;
                bus.cmd_inputs_1    = op1;
                if (bus.cmd_ready)
                    state_nxt = WAIT_RSP;
            end
            WAIT_RSP: begin
                bus.rsp_ready = 1'b1;
                if (bus.rsp_valid) begin
                    state_nxt = ISSUE;
                    case (phase)
                        PH_RST:   phase_nxt = (npairs == 8'd0) ? PH_SET0 : PH_SET;
                        PH_SET: begin
                            phase_nxt = PH_STORE;
                            state_nxt = FETCH_LO;
                        end
                        PH_STORE: begin
                            if (last_pair) begin
                                phase_nxt = PH_SET0;
                                idx_nxt   = '0;
                            end else begin
                                phase_nxt = PH_SET;
                                idx_nxt   = idx + 8'd1;
                            end
                        end
                        PH_SET0: begin
                            if (npairs == 8'd0) begin
                                phase_nxt = PH_READ;
                            end else begin
                                phase_nxt = PH_MAC;
                                state_nxt = FETCH_LO;
                            end
                        end
                        PH_MAC: begin
                            if (last_pair) begin
                                phase_nxt = PH_READ;
                                idx_nxt   = '0;
                            end else begin
                                idx_nxt   = idx + 8'd1;
                                state_nxt = FETCH_LO;
                            end
                        end
                        default: state_nxt = DONE;
                    endcase
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cfu_cmd_sequencer.sv
// Directed bench: behavioural CFU responder with programmable command stall
// and response delay, a 1-cycle read memory, and logs of commands and reads.
module tb_cfu_cmd_sequencer;
    localparam int ADDR_W = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        sel_buf = 1'b0;
    logic [7:0]  num_pairs = '0;
    logic [15:0] in_base = '0;
    logic [15:0] flt_base = '0;
    logic        busy, done, err;
    logic [31:0] result;

    cfu_cmd_sequencer_if #(.ADDR_W(ADDR_W)) ifc ();

    cfu_cmd_sequencer #(.ADDR_W(ADDR_W), .MAX_PAIRS(82)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_pairs (num_pairs),
        .in_base   (in_base),
        .flt_base  (flt_base),
        .sel_buf   (sel_buf),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .result    (result),
        .bus       (ifc)
    );

    always #5 clk = ~clk;

    // knobs
    int          stall_at = -1;
    int          stall_n = 0;
    int          rsp_delay = 0;
    logic [31:0] read_val = '0;
    logic        clr = 1'b0;

    logic [31:0] mem [0:65535];

    // logs and monitors
    logic [9:0]  log_fid [0:299];
    logic [31:0] log_in0 [0:299];
    logic [31:0] log_in1 [0:299];
    logic [15:0] rd_addr [0:399];
    int cyc = 0, cmd_cnt = 0, rd_cnt = 0, done_cnt = 0;
    int done_cyc = 0, acc_cyc = 0, start_cyc = 0;
    int unstable = 0, overlap = 0, stall_seen = 0, waited = 0, rwait = 0;
    logic pend = 1'b0, pend_read = 1'b0, held = 1'b0;
    logic err_at_done = 1'b0, busy_at_done = 1'b0;
    logic [73:0] hold_pl = '0;

    int checks = 0, failures = 0;
    int d0;

    assign ifc.cmd_ready = !(cmd_cnt == stall_at && waited < stall_n);

    // Memory, CFU responder and event monitors.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ifc.mem_rd_en) begin
            ifc.mem_rdata <= mem[ifc.mem_addr];
            if (rd_cnt < 400) rd_addr[rd_cnt] <= ifc.mem_addr;
            rd_cnt <= rd_cnt + 1;
        end
        if (done) begin
            done_cnt     <= done_cnt + 1;
            done_cyc     <= cyc;
            err_at_done  <= err;
            busy_at_done <= busy;
        end
        if (start && !busy && !done && !reset) start_cyc <= cyc;
        if (reset) begin
            ifc.rsp_valid <= 1'b0;
            pend          <= 1'b0;
            waited        <= 0;
            held          <= 1'b0;
        end else begin
            held    <= ifc.cmd_valid && !ifc.cmd_ready;
            hold_pl <= {ifc.cmd_function_id, ifc.cmd_inputs_0, ifc.cmd_inputs_1};
            if (held && (!ifc.cmd_valid ||
                {ifc.cmd_function_id, ifc.cmd_inputs_0, ifc.cmd_inputs_1} != hold_pl))
                unstable <= unstable + 1;
            if (ifc.cmd_valid && pend) overlap <= overlap + 1;
            if (ifc.cmd_valid && !ifc.cmd_ready) begin
                stall_seen <= stall_seen + 1;
                waited     <= waited + 1;
            end
            if (ifc.cmd_valid && ifc.cmd_ready) begin
                if (cmd_cnt < 300) begin
                    log_fid[cmd_cnt] <= ifc.cmd_function_id;
                    log_in0[cmd_cnt] <= ifc.cmd_inputs_0;
                    log_in1[cmd_cnt] <= ifc.cmd_inputs_1;
                end
                cmd_cnt   <= cmd_cnt + 1;
                waited    <= 0;
                pend      <= 1'b1;
                rwait     <= rsp_delay;
                pend_read <= (ifc.cmd_function_id == 10'd25) || (ifc.cmd_function_id == 10'd49);
            end
            if (pend && !ifc.rsp_valid) begin
                if (rwait == 0) begin
                    ifc.rsp_valid     <= 1'b1;
                    ifc.rsp_outputs_0 <= pend_read ? read_val : (32'hBAD0_0000 + 32'(cmd_cnt));
                end else begin
                    rwait <= rwait - 1;
                end
            end
            if (ifc.rsp_valid && ifc.rsp_ready) begin
                ifc.rsp_valid <= 1'b0;
                pend          <= 1'b0;
                acc_cyc       <= cyc;
            end
        end
        if (clr) begin
            cmd_cnt    <= 0;
            rd_cnt     <= 0;
            unstable   <= 0;
            overlap    <= 0;
            stall_seen <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [7:0] p, input logic s, input logic [15:0] ib, input logic [15:0] fb);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        num_pairs = p; sel_buf = s; in_base = ib; flt_base = fb; start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic run_job(input logic [7:0] p, input logic s, input logic [15:0] ib,
                           input logic [15:0] fb, input int bound);
        int dc;
        dc = done_cnt;
        launch(p, s, ib, fb);
        for (int i = 0; i < bound && done_cnt == dc; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("done_once", 32'(done_cnt - dc), 32'd1);
        chk("done_low_after", {31'd0, done}, 32'd0);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 32'hA500_0000 | 32'(a);

        // reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_result", result, 0);
        chk("rst_cmd_valid", {31'd0, ifc.cmd_valid}, 0);
        chk("rst_rsp_ready", {31'd0, ifc.rsp_ready}, 0);
        chk("rst_mem_rd_en", {31'd0, ifc.mem_rd_en}, 0);
        chk("rst_fid", {22'd0, ifc.cmd_function_id}, 0);
        reset = 1'b0;

        // P=1, buffer 0
        mem[16'h0100] = 32'h0; mem[16'h0101] = 32'h0;
        mem[16'h0200] = 32'h0101_0101; mem[16'h0201] = 32'h0101_0101;
        read_val = 32'd1024;
        run_job(8'd1, 1'b0, 16'h0100, 16'h0200, 200);
        chk("p1_cmds", cmd_cnt, 6);
        chk("p1_fid0", {22'd0, log_fid[0]}, 0);
        chk("p1_fid1", {22'd0, log_fid[1]}, 1);
        chk("p1_set_in0", log_in0[1], 0);
        chk("p1_fid2", {22'd0, log_fid[2]}, 9);
        chk("p1_fid3", {22'd0, log_fid[3]}, 1);
        chk("p1_fid4", {22'd0, log_fid[4]}, 16);
        chk("p1_mac_in0", log_in0[4], 32'h0101_0101);
        chk("p1_mac_in1", log_in1[4], 32'h0101_0101);
        chk("p1_fid5", {22'd0, log_fid[5]}, 25);
        chk("p1_result", result, 32'd1024);
        chk("p1_err", {31'd0, err_at_done}, 0);
        chk("p1_done_lat", 32'(done_cyc - acc_cyc), 1);
        chk("p1_busy_at_done", {31'd0, busy_at_done}, 0);
        chk("p1_reads", rd_cnt, 4);
        chk("p1_overlap", overlap, 0);

        // P=2, buffer 1, address wrap, backpressure
        mem[16'hFFFE] = 32'h1111_1111; mem[16'hFFFF] = 32'h2222_2222;
        mem[16'h0000] = 32'h3333_3333; mem[16'h0001] = 32'h4444_4444;
        read_val = 32'hCAFE_F00D; stall_at = 1; stall_n = 3; rsp_delay = 5;
        run_job(8'd2, 1'b1, 16'hFFFE, 16'h0300, 400);
        chk("p2_cmds", cmd_cnt, 9);
        chk("p2_reads", rd_cnt, 8);
        chk("p2_rd0", {16'd0, rd_addr[0]}, 32'hFFFE);
        chk("p2_rd1", {16'd0, rd_addr[1]}, 32'hFFFF);
        chk("p2_rd2", {16'd0, rd_addr[2]}, 32'h0000);
        chk("p2_rd3", {16'd0, rd_addr[3]}, 32'h0001);
        chk("p2_rd4", {16'd0, rd_addr[4]}, 32'h0300);
        chk("p2_rd7", {16'd0, rd_addr[7]}, 32'h0303);
        chk("p2_store_fid", {22'd0, log_fid[2]}, 33);
        chk("p2_store0_in0", log_in0[2], 32'h1111_1111);
        chk("p2_store0_in1", log_in1[2], 32'h2222_2222);
        chk("p2_set1_in0", log_in0[3], 2);
        chk("p2_store1_in0", log_in0[4], 32'h3333_3333);
        chk("p2_store1_in1", log_in1[4], 32'h4444_4444);
        chk("p2_set0_in0", log_in0[5], 0);
        chk("p2_mac0_in0", log_in0[6], 32'hA500_0300);
        chk("p2_mac0_in1", log_in1[6], 32'hA500_0301);
        chk("p2_mac1_in0", log_in0[7], 32'hA500_0302);
        chk("p2_read_fid", {22'd0, log_fid[8]}, 49);
        chk("p2_result", result, 32'hCAFE_F00D);
        chk("p2_stall_cycles", stall_seen, 3);
        chk("p2_payload_stable", unstable, 0);
        chk("p2_overlap", overlap, 0);
        chk("p2_done_lat", 32'(done_cyc - acc_cyc), 1);

        // P=0
        stall_at = -1; rsp_delay = 1; read_val = 32'h1234_5678;
        run_job(8'd0, 1'b0, 16'h0010, 16'h0020, 100);
        chk("p0_cmds", cmd_cnt, 3);
        chk("p0_reads", rd_cnt, 0);
        chk("p0_fid0", {22'd0, log_fid[0]}, 0);
        chk("p0_fid1", {22'd0, log_fid[1]}, 1);
        chk("p0_fid2", {22'd0, log_fid[2]}, 25);
        chk("p0_result", result, 32'h1234_5678);

        // P=83 rejected
        read_val = 32'h5555_AAAA;
        run_job(8'd83, 1'b0, 16'h0010, 16'h0020, 20);
        chk("p83_cmds", cmd_cnt, 0);
        chk("p83_reads", rd_cnt, 0);
        chk("p83_err", {31'd0, err_at_done}, 1);
        chk("p83_lat", 32'(done_cyc - start_cyc), 1);
        chk("p83_result_kept", result, 32'h1234_5678);

        // P=82 maximum
        rsp_delay = 0; read_val = 32'h0000_BEEF;
        run_job(8'd82, 1'b0, 16'h1000, 16'h2000, 5000);
        chk("p82_cmds", cmd_cnt, 249);
        chk("p82_reads", rd_cnt, 328);
        chk("p82_err", {31'd0, err_at_done}, 0);
        chk("p82_set81_in0", log_in0[163], 162);
        chk("p82_store81_in0", log_in0[164], 32'hA500_10A2);
        chk("p82_store81_in1", log_in1[164], 32'hA500_10A3);
        chk("p82_mac81_fid", {22'd0, log_fid[247]}, 16);
        chk("p82_mac81_in0", log_in0[247], 32'hA500_20A2);
        chk("p82_mac81_in1", log_in1[247], 32'hA500_20A3);
        chk("p82_read_fid", {22'd0, log_fid[248]}, 25);
        chk("p82_result", result, 32'h0000_BEEF);

        // reset while waiting on a MAC response
        rsp_delay = 20;
        launch(8'd2, 1'b0, 16'h0100, 16'h0200);
        for (int i = 0; i < 300 && cmd_cnt < 7; i++) @(negedge clk);
        chk("rstjob_reached_mac", cmd_cnt, 7);
        chk("rstjob_mac_fid", {22'd0, log_fid[6]}, 16);
        chk("rstjob_rsp_ready_pre", {31'd0, ifc.rsp_ready}, 1);
        d0 = done_cnt;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rstjob_busy", {31'd0, busy}, 0);
        chk("rstjob_cmd_valid", {31'd0, ifc.cmd_valid}, 0);
        chk("rstjob_rsp_ready", {31'd0, ifc.rsp_ready}, 0);
        @(negedge clk); reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("rstjob_no_done", 32'(done_cnt - d0), 0);
        rsp_delay = 0; read_val = 32'h0000_600D;
        run_job(8'd1, 1'b0, 16'h0100, 16'h0200, 200);
        chk("rerun_cmds", cmd_cnt, 6);
        chk("rerun_mac_in0", log_in0[4], 32'h0101_0101);
        chk("rerun_result", result, 32'h0000_600D);
        chk("rerun_err", {31'd0, err_at_done}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
